// File: rtl/pla_sweep_pkg.sv
// Shared definitions for the PLA truth-table sweeper.
//   sweep_state_e : sweep controller states (IDLE / SWEEP / DRAIN)
//   MISR_POLY     : feedback polynomial for the optional signature register;
//                   the low WORD_W bits are used
//   num_words()   : number of truth-table words for a 2^n_in sweep
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } sweep_state_e;

  localparam logic [63:0] MISR_POLY = 64'h42F0_E1EB_A9EA_3693;

  function automatic int num_words(input int n_in, input int word_w);
    return (1 << n_in) / word_w;
  endfunction

endpackage

// File: rtl/pla_tt_packer.sv
// Shift-in truth-table packer with a one-word output holding register.
// Captured result bits are placed at increasing bit positions. A full
// word moves into the holding register, which drives the valid/ready
// stream. The stall output tells the vector issuer when one more issued
// vector could not be absorbed.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             restart packing at word 0, bit 0 (new sweep)
//   in_valid, in_bit  one captured function output bit
//   inflight          number of issued vectors whose result is still pending
//   stall             hold off issuing the next vector
//   tt_data/tt_valid/tt_last/tt_ready  truth-table word stream
module pla_tt_packer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int IF_W      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic [IF_W-1:0]   inflight,
  output logic              stall,
  output logic [WORD_W-1:0] tt_data,
  output logic              tt_valid,
  output logic              tt_last,
  input  logic              tt_ready
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam int PC_W  = IDX_W + 1;
  localparam int WC_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [WORD_W-1:0] pack_q, pack_d;
  logic [PC_W-1:0]   pack_cnt_q, pack_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              hold_valid_q, hold_valid_d;
  logic [WORD_W-1:0] hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;

  logic              pack_full;
  logic              move;
  logic [31:0]       credit;
  logic [PC_W-1:0]   base_cnt;
  logic [WORD_W-1:0] base_word;

  // Kept out of the packing always_comb so that stall never appears to
  // depend on in_valid (in_valid is derived from stall when DUT_LAT is 0).
  assign pack_full = (pack_cnt_q == PC_W'(WORD_W));
  assign move      = pack_full && (!hold_valid_q || tt_ready);
  // Bits already in the packer plus bits still in flight must leave room
  // for one more vector whenever the holding register cannot drain.
  assign credit    = 32'(pack_cnt_q) + 32'(inflight);
  assign stall     = hold_valid_q && !tt_ready && (credit >= 32'(WORD_W));

  assign tt_data  = hold_data_q;
  assign tt_valid = hold_valid_q;
  assign tt_last  = hold_last_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    word_cnt_d   = word_cnt_q;
    base_cnt     = pack_cnt_q;
    base_word    = pack_q;

    if (hold_valid_q && tt_ready) begin
      hold_valid_d = 1'b0;
    end

    if (move) begin
      hold_valid_d = 1'b1;
      hold_data_d  = pack_q;
      hold_last_d  = (word_cnt_q == WC_W'(NUM_WORDS - 1));
      word_cnt_d   = (word_cnt_q == WC_W'(NUM_WORDS - 1)) ? '0 : word_cnt_q + WC_W'(1);
      base_cnt     = '0;
      base_word    = '0;
    end

    // An arriving bit lands behind whatever survives the move above, so
    // the bit of the cycle a word leaves becomes bit 0 of the next word.
    pack_d     = base_word;
    pack_cnt_d = base_cnt;
    if (in_valid) begin
      pack_d[base_cnt[IDX_W-1:0]] = in_bit;
      pack_cnt_d                  = base_cnt + PC_W'(1);
    end

    if (clear) begin
      pack_d     = '0;
      pack_cnt_d = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q       <= '0;
      pack_cnt_q   <= '0;
      word_cnt_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
    end else begin
      pack_q       <= pack_d;
      pack_cnt_q   <= pack_cnt_d;
      word_cnt_q   <= word_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
    end
  end

endmodule

// File: rtl/pla_truth_table_sweeper.sv
// Truth-table sweeper for a single-output logic function of N_IN inputs.
// On start it drives every input vector 0..2^N_IN-1 on x_out, captures y_in
// DUT_LAT cycles later, packs the results into WORD_W-bit words streamed
// over valid/ready, and counts the ones of the function.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin a sweep (ignored while busy)
//   busy, done                 sweep in progress / last word accepted pulse
//   x_out, y_in                function input vector / function output
//   tt_data/tt_valid/tt_ready/tt_last  truth-table word stream
//   ones_cnt                   number of input vectors with y = 1
//   misr_sig                   word signature, only with PLA_SWEEP_MISR_EN
// Optional feature macro: PLA_SWEEP_MISR_EN adds the misr_sig output.
module pla_truth_table_sweeper
  import pla_sweep_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int WORD_W  = 32,
  parameter int DUT_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  output logic [WORD_W-1:0] tt_data,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic              tt_last,
  output logic [N_IN:0]     ones_cnt
`ifdef PLA_SWEEP_MISR_EN
  ,
  output logic [WORD_W-1:0] misr_sig
`endif
);

  localparam int NUM_WORDS = num_words(N_IN, WORD_W);
  localparam int IF_W      = $clog2(DUT_LAT + 2);
  localparam int OC_W      = N_IN + 1;

  sweep_state_e      state_q, state_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [OC_W-1:0]   ones_q, ones_d;
  logic              start_acc;
  logic              issue;
  logic              stall;
  logic              cap_valid;
  logic [IF_W-1:0]   inflight;

  assign busy     = (state_q != IDLE);
  assign x_out    = x_q;
  assign ones_cnt = ones_q;
  assign issue    = (state_q == SWEEP) && !stall;

  // Valid tags follow each issued vector through the function's latency,
  // so y_in is only captured for real vectors and stalls become bubbles.
  generate
    if (DUT_LAT == 0) begin : g_no_lat
      assign cap_valid = issue;
      assign inflight  = '0;
    end else begin : g_lat
      logic [DUT_LAT-1:0] tag_q, tag_d;
      always_comb begin
        tag_d = DUT_LAT'({tag_q, issue});
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_q <= '0;
        end else begin
          tag_q <= tag_d;
        end
      end
      assign cap_valid = tag_q[DUT_LAT-1];
      assign inflight  = IF_W'($countones(tag_q));
    end
  endgenerate

  pla_tt_packer #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .IF_W     (IF_W)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_acc),
    .in_valid(cap_valid),
    .in_bit  (y_in),
    .inflight(inflight),
    .stall   (stall),
    .tt_data (tt_data),
    .tt_valid(tt_valid),
    .tt_last (tt_last),
    .tt_ready(tt_ready)
  );

  // Sweep control: the vector counter wraps to 0 after the final vector,
  // which leaves x_out at 0 through DRAIN and IDLE.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    ones_d    = ones_q;
    start_acc = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        x_d = '0;
        if (start) begin
          start_acc = 1'b1;
          state_d   = SWEEP;
        end
      end
      SWEEP: begin
        if (issue) begin
          x_d = x_q + N_IN'(1);
          if (x_q == '1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (tt_valid && tt_ready && tt_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cap_valid && y_in) begin
      ones_d = ones_q + OC_W'(1);
    end
    if (start_acc) begin
      ones_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ones_q  <= ones_d;
    end
  end

`ifdef PLA_SWEEP_MISR_EN
  localparam logic [WORD_W-1:0] POLY = MISR_POLY[WORD_W-1:0];

  logic [WORD_W-1:0] misr_q, misr_d;

  // Galois-style MISR: shift, fold the polynomial on carry-out, and mix in
  // each word as it is accepted downstream.
  always_comb begin
    misr_d = misr_q;
    if (start_acc) begin
      misr_d = '1;
    end else if (tt_valid && tt_ready) begin
      misr_d = {misr_q[WORD_W-2:0], 1'b0} ^ (misr_q[WORD_W-1] ? POLY : '0) ^ tt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign misr_sig = misr_q;
`endif

endmodule

// File: tb/tb_pla_truth_table_sweeper.sv
// Self-checking bench for pla_truth_table_sweeper. A registered two-stage
// model of the swept function feeds y_in; the expected words, last flags,
// done pulses and ones counts come from the function's truth table.
// Optional feature macro: PLA_SWEEP_MISR_EN enables the signature checks.
module tb_pla_truth_table_sweeper;
`ifdef PLA_SWEEP_MISR_EN
  import pla_sweep_pkg::*;
`endif

  localparam int N_IN      = 8;
  localparam int WORD_W    = 32;
  localparam int DUT_LAT   = 2;
  localparam int NUM_VEC   = 1 << N_IN;
  localparam int NUM_WORDS = NUM_VEC / WORD_W;
  localparam int LAT_MAX   = NUM_VEC + DUT_LAT + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [N_IN-1:0]   x_out;
  logic              y_in;
  logic [WORD_W-1:0] tt_data;
  logic              tt_valid;
  logic              tt_ready;
  logic              tt_last;
  logic [N_IN:0]     ones_cnt;
`ifdef PLA_SWEEP_MISR_EN
  logic [WORD_W-1:0] misr_sig;
`endif

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [NUM_VEC-1:0] truth;
  logic [WORD_W-1:0]  got_words [NUM_WORDS];
  logic               y_p0, y_p1;

  always #5 clk = ~clk;

  pla_truth_table_sweeper #(
    .N_IN   (N_IN),
    .WORD_W (WORD_W),
    .DUT_LAT(DUT_LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .x_out   (x_out),
    .y_in    (y_in),
    .tt_data (tt_data),
    .tt_valid(tt_valid),
    .tt_ready(tt_ready),
    .tt_last (tt_last),
    .ones_cnt(ones_cnt)
`ifdef PLA_SWEEP_MISR_EN
    ,
    .misr_sig(misr_sig)
`endif
  );

  // The function under sweep, registered twice to give DUT_LAT = 2.
  always @(posedge clk) begin
    y_p0 <= truth[x_out];
    y_p1 <= y_p0;
  end
  assign y_in = y_p1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkMax(input string name, input int actual, input int limit);
    checks++;
    if (actual > limit) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required<=%0d", name, actual, limit);
    end
  endtask

  function automatic logic goldenF(input logic [N_IN-1:0] v);
    logic [7:0] h;
    h = 8'(v * 8'd29 + 8'd7);
    return h[3] ^ (v[7] & v[2]) ^ (v[0] & v[4] & ~v[6]);
  endfunction

  task automatic setTruth(input int sel);
    logic [N_IN-1:0] xv;
    for (int v = 0; v < NUM_VEC; v++) begin
      xv = N_IN'(v);
      case (sel)
        0:       truth[v] = 1'b0;
        1:       truth[v] = xv[0];
        2:       truth[v] = xv[5];
        3:       truth[v] = goldenF(xv);
        default: truth[v] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

`ifdef PLA_SWEEP_MISR_EN
  function automatic logic [WORD_W-1:0] misrRef();
    logic [WORD_W-1:0] m;
    logic [WORD_W-1:0] poly;
    m    = '1;
    poly = MISR_POLY[WORD_W-1:0];
    for (int w = 0; w < NUM_WORDS; w++) begin
      m = {m[WORD_W-2:0], 1'b0} ^ (m[WORD_W-1] ? poly : '0) ^ truth[w*WORD_W +: WORD_W];
    end
    return m;
  endfunction
`endif

  task automatic checkResetValues();
    checkOutput("rst_x_out",    64'(x_out),    64'd0);
    checkOutput("rst_busy",     64'(busy),     64'd0);
    checkOutput("rst_done",     64'(done),     64'd0);
    checkOutput("rst_tt_valid", 64'(tt_valid), 64'd0);
    checkOutput("rst_tt_last",  64'(tt_last),  64'd0);
    checkOutput("rst_tt_data",  64'(tt_data),  64'd0);
    checkOutput("rst_ones_cnt", 64'(ones_cnt), 64'd0);
  endtask

  // Per-cycle compare process: word contents and order, last flag, done
  // pulse, stream stability under back-pressure and vector stepping.
  int                word_idx  = 0;
  logic              hold_chk  = 1'b0;
  logic [WORD_W-1:0] held_data;
  logic              held_last;
  logic              prev_busy = 1'b0;
  logic [N_IN-1:0]   prev_x;
  logic              exp_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      word_idx  = 0;
      hold_chk  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (hold_chk) begin
        checkOutput("stall_valid", 64'(tt_valid), 64'd1);
        checkOutput("stall_data",  64'(tt_data),  64'(held_data));
        checkOutput("stall_last",  64'(tt_last),  64'(held_last));
      end
      exp_done = tt_valid && tt_ready && (word_idx == NUM_WORDS - 1);
      checkOutput("done_pulse", 64'(done), 64'(exp_done));
      if (tt_valid && tt_ready) begin
        if (word_idx < NUM_WORDS) begin
          checkOutput("word_data", 64'(tt_data), 64'(truth[word_idx*WORD_W +: WORD_W]));
          checkOutput("word_last", 64'(tt_last), 64'(word_idx == NUM_WORDS - 1));
          got_words[word_idx] = tt_data;
          word_idx++;
        end else begin
          checkOutput("extra_word", 64'(word_idx), 64'(NUM_WORDS - 1));
        end
      end
      if (done) begin
        done_cnt++;
        checkOutput("ones_cnt_done", 64'(ones_cnt), 64'($countones(truth)));
        word_idx = 0;
      end
      if (busy && prev_busy) begin
        checkOutput("x_step", 64'((x_out == prev_x) || (x_out == N_IN'(prev_x + 1'b1))), 64'd1);
      end
      hold_chk  = tt_valid && !tt_ready;
      held_data = tt_data;
      held_last = tt_last;
      prev_busy = busy;
      prev_x    = x_out;
    end
  end

  // mode 0: tt_ready always high (full rate, latency bound checked)
  // mode 1: random tt_ready with a 100-cycle low burst (x_out must freeze)
  // mode 2: random tt_ready
  // mode 3: random tt_ready, start pulsed mid-sweep and in the done cycle
  task automatic applyStimulus(input int sel, input int mode);
    int              d0;
    int              lat;
    bit              seen;
    logic [N_IN-1:0] x_mark;
    setTruth(sel);
    d0   = done_cnt;
    seen = 1'b0;
    lat  = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    tt_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tt_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (mode == 1 && c >= 20 && c < 120) tt_ready = 1'b0;
      start = (mode == 3 && c == 40);
      #1;
      if (mode == 1 && c == 90) x_mark = x_out;
      if (mode == 1 && c == 119) begin
        checkOutput("stall_x_frozen", 64'(x_out), 64'(x_mark));
        checkOutput("stall_busy",     64'(busy),  64'd1);
      end
      if (done) begin
        seen = 1'b1;
        lat  = c + 1;
        if (mode == 3) start = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) checkOutput("done_timeout", 64'(seen), 64'd1);
    if (mode == 0) checkMax("done_latency", lat, LAT_MAX);
    @(posedge clk); #1;
    start    = 1'b0;
    tt_ready = 1'b1;
    checkOutput("idle_after_done", 64'(busy), 64'd0);
    checkOutput("one_done", 64'(done_cnt), 64'(d0 + 1));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("still_idle",    64'(busy),     64'd0);
    checkOutput("ones_cnt_hold", 64'(ones_cnt), 64'($countones(truth)));
    checkOutput("x_out_idle",    64'(x_out),    64'd0);
  endtask

  task automatic abortSweep();
    int d0;
    bit hit;
    setTruth(3);
    d0  = done_cnt;
    hit = 1'b0;
    @(posedge clk); #1;
    start    = 1'b1;
    tt_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (x_out == N_IN'(100)) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("abort_reach_100", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    checkResetValues();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 64'(done_cnt), 64'(d0));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    tt_ready = 1'b1;
    truth    = '0;
    #1;
    checkResetValues();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(0, 0);
    checkOutput("const0_word0", 64'(got_words[0]), 64'h0);
    checkOutput("const0_word7", 64'(got_words[7]), 64'h0);
    checkOutput("const0_ones",  64'(ones_cnt),     64'd0);
`ifdef PLA_SWEEP_MISR_EN
    checkOutput("misr_first",  64'(misr_sig), 64'(misrRef()));
    applyStimulus(0, 0);
    checkOutput("misr_second", 64'(misr_sig), 64'(misrRef()));
`endif

    applyStimulus(1, 0);
    checkOutput("x0_word0", 64'(got_words[0]), 64'hAAAA_AAAA);
    checkOutput("x0_word7", 64'(got_words[7]), 64'hAAAA_AAAA);
    checkOutput("x0_ones",  64'(ones_cnt),     64'd128);

    applyStimulus(2, 0);
    checkOutput("x5_word0", 64'(got_words[0]), 64'h0);
    checkOutput("x5_word1", 64'(got_words[1]), 64'hFFFF_FFFF);
    checkOutput("x5_word6", 64'(got_words[6]), 64'h0);
    checkOutput("x5_word7", 64'(got_words[7]), 64'hFFFF_FFFF);
    checkOutput("x5_ones",  64'(ones_cnt),     64'd128);

    applyStimulus(3, 1);
    abortSweep();
    applyStimulus(3, 0);
    applyStimulus(4, 3);
    for (int k = 0; k < 3; k++) applyStimulus(4, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pla_truth_table_sweeper.md
Name:
pla_truth_table_sweeper

Overview:
- Sequential stimulus/capture stage wrapped around one single-output benchmark logic function (8 inputs x0..x7 → y0).
- On start, applies every input vector 0..2^N_IN−1 in order and samples the function output, accounting for a configurable DUT pipeline latency.
- Packs the resulting truth table into WORD_W-bit words streamed out over a valid/ready handshake, and counts ones (minterms).
- Feeds downstream autosymmetry/equivalence checkers that compare original and optimized netlists.

Parameters:
- N_IN, 8, number of function inputs; sweep length is 2^N_IN.
- WORD_W, 32, truth-table word width; power of two, ≤ 2^N_IN.
- DUT_LAT, 0, cycles from x_out change to a valid y_in; 0 = combinational, sampled in the same cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins a sweep; ignored while busy.
- busy  out  1  high from accepted start until the last word is accepted.
- done  out  1  one-cycle pulse when the last word is accepted.
- x_out  out  N_IN  vector to the function; x_out[0]=x0.
- y_in  in  1  function output.
- tt_data  out  WORD_W  truth-table word; bit i = f(word_idx*WORD_W+i).
- tt_valid  out  1  tt_data valid.
- tt_ready  in  1  downstream accept.
- tt_last  out  1  marks the final word (index 2^N_IN/WORD_W−1).
- ones_cnt  out  N_IN+1  number of vectors with y=1.

Behaviour:
- Async reset (rst_n low): state IDLE; x_out=0, busy=0, done=0, tt_valid=0, tt_last=0, tt_data=0, ones_cnt=0; internal counters and pipeline cleared.
- States: IDLE → SWEEP on start → DRAIN once vector 2^N_IN−1 is issued → back to IDLE when the last word handshakes, with done pulsed that cycle.
- SWEEP:
  - Each non-stalled cycle, x_out increments by 1 (first vector 0, presented the cycle after start).
  - A valid-tag pipeline of depth DUT_LAT tracks in-flight vectors.
  - A tagged y_in shifts into the packer at bit position pack_cnt.
- Holding register: one word deep, driving tt_data/tt_valid/tt_last.
  - A full packer word moves into it when it is empty, or when it is being accepted in that same cycle.
  - tt_data/tt_last are stable while tt_valid && !tt_ready.
- Stall rule: hold issuing new vectors (x_out frozen, tag pipeline inserts bubble) when holding register is full && !tt_ready && (pack_cnt + inflight) ≥ WORD_W. No result bit is ever dropped or duplicated.
- Full-rate throughput with tt_ready=1: one vector per cycle. Last word is valid no later than 2^N_IN + DUT_LAT + 2 cycles after start.
- ones_cnt:
  - Cleared on accepted start; increments per captured 1.
  - Holds its final value (max 2^N_IN, hence N_IN+1 bits) until the next start.
- Start in the same cycle as done: ignored. Start while busy: ignored with no side effects.
- Reset mid-sweep: immediate abort to reset values; no done pulse.
- x_out returns to 0 in IDLE.

Optional Feature:
- Macro: PLA_SWEEP_MISR_EN.
- When defined:
  - Adds output misr_sig [WORD_W].
  - This is a MISR (polynomial constant in package), seeded to all-ones on start.
  - It is updated with each accepted tt_data word and is stable from done until the next start.
- When undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pla_sweep_pkg:
  - state enum (IDLE/SWEEP/DRAIN);
  - MISR polynomial constant;
  - localparam function for word count 2^N_IN/WORD_W.
- One natural sub-module: pla_tt_packer (shift-in packer plus one-word holding register with valid/ready and stall-credit output).

Test Plan:
- y_in tied 0, N_IN=8, WORD_W=32, tt_ready=1 → 8 words of 0x00000000, tt_last only on word 7, ones_cnt=0, done within 260 cycles of start.
- y_in = x_out[0] → every word 0xAAAAAAAA; y_in = x_out[5] → words alternate 0x00000000/0xFFFFFFFF; ones_cnt=128 in both.
- Golden model of the m4 benchmark function, DUT_LAT=2 (registered model), random tt_ready with a 100-cycle low burst → all 8 words match the golden truth table, x_out frozen during stall, ones_cnt matches golden popcount.
- rst_n asserted at vector 100, released, then new start → outputs at reset values, no done, second sweep yields complete correct 8 words.
- start pulsed while busy and in the done cycle → ignored, exactly one done per accepted start.
- PLA_SWEEP_MISR_EN defined, constant-0 function → misr_sig equals the precomputed reference after 8 zero words; identical across two back-to-back sweeps.
